// File: rtl/freq_monitor_pkg.sv
// freq_monitor_pkg: shared state encoding and constants for the frequency monitor sequencer
package freq_monitor_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t LOAD    = 3'd1;
  localparam state_t MEASURE = 3'd2;
  localparam state_t GRADE   = 3'd3;
  localparam state_t DRAIN   = 3'd4;
  localparam state_t GAP     = 3'd5;
  localparam int DRAIN_LOW_CYCLES = 2;
endpackage

// File: rtl/freq_monitor_ctrl_if.sv
// freq_monitor_ctrl_if: handshake between the sequencer (master) and the freq_comparator (slave)
interface freq_monitor_ctrl_if #(parameter int DATA_WIDTH = 32);
  logic                  cmp_enable;
  logic [DATA_WIDTH-1:0] cmp_timeout;
  logic                  cmp_ge;
  logic                  cmp_done;
  modport master (output cmp_enable, cmp_timeout, input cmp_ge, cmp_done);
  modport slave (input cmp_enable, cmp_timeout, output cmp_ge, cmp_done);
endinterface

// File: rtl/freq_monitor_wdog.sv
// freq_monitor_wdog: clearable up-counter flagging when the count equals the configured limit
module freq_monitor_wdog #(parameter int WIDTH = 40) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] cfg,
  output logic             expired
);
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset_n || clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign expired = cnt == cfg;
endmodule

// File: rtl/freq_monitor_ctrl.sv
// freq_monitor_ctrl: launches comparator measurements, grades results, tracks failures and watchdog
module freq_monitor_ctrl
  import freq_monitor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FAIL_WIDTH = 4,
  parameter int GAP_WIDTH  = 16,
  parameter int WDOG_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  input  logic                  expect_ge,
  input  logic [DATA_WIDTH-1:0] window_cfg,
  input  logic [GAP_WIDTH-1:0]  gap_cfg,
  input  logic [FAIL_WIDTH-1:0] fail_thresh,
  input  logic [WDOG_WIDTH-1:0] wdog_cfg,
  input  logic                  alarm_clr,
  freq_monitor_ctrl_if.master   cmp,
  output logic                  busy,
  output logic                  meas_valid,
  output logic                  meas_pass,
  output logic [FAIL_WIDTH-1:0] fail_cnt,
  output logic                  alarm,
  output logic                  wdog_err
);
  state_t state, nxt;
  logic stop_req, expect_s, cnt_exp;
  logic [1:0] low_cnt;
  logic [GAP_WIDTH-1:0] gap_last;
  logic [FAIL_WIDTH-1:0] fail_nxt;
  logic stop_now, grading, wdog_hit, drained, pass_now;
  assign stop_now = stop_req | stop;
  assign grading  = state == MEASURE && cmp.cmp_done;
  assign wdog_hit = state == MEASURE && !cmp.cmp_done && wdog_cfg != '0 && cnt_exp;
  assign drained  = !cmp.cmp_done && low_cnt == 2'(DRAIN_LOW_CYCLES - 1);
  assign pass_now = cmp.cmp_ge == expect_s;
  assign fail_nxt = pass_now ? '0 : (&fail_cnt ? fail_cnt : fail_cnt + 1'b1);
  assign gap_last = gap_cfg - 1'b1;
  assign busy     = state != IDLE;
  // One counter serves as the MEASURE watchdog and the GAP timer; it is held clear elsewhere
  freq_monitor_wdog #(.WIDTH(WDOG_WIDTH)) u_wdog (
    .clk(clk),
    .reset_n(reset_n),
    .clr(state != MEASURE && state != GAP),
    .inc(1'b1),
    .cfg(state == GAP ? WDOG_WIDTH'(gap_last) : wdog_cfg),
    .expired(cnt_exp)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = MEASURE;
      MEASURE: nxt = grading ? GRADE : (wdog_hit ? DRAIN : MEASURE);
      GRADE:   nxt = DRAIN;
      DRAIN:   nxt = !drained ? DRAIN : (continuous && !stop_now) ? (gap_cfg != '0 ? GAP : LOAD) : IDLE;
      GAP:     nxt = stop_now ? IDLE : (cnt_exp ? LOAD : GAP);
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      stop_req        <= 1'b0;
      expect_s        <= 1'b0;
      low_cnt         <= '0;
      cmp.cmp_enable  <= 1'b0;
      cmp.cmp_timeout <= '0;
      meas_valid      <= 1'b0;
      meas_pass       <= 1'b0;
      fail_cnt        <= '0;
      alarm           <= 1'b0;
      wdog_err        <= 1'b0;
    end else begin
      state          <= nxt;
      cmp.cmp_enable <= nxt == MEASURE;
      meas_valid     <= grading;
      stop_req       <= (stop && state != IDLE) || (stop_req && state != LOAD);
      low_cnt        <= (state == DRAIN && !cmp.cmp_done) ? low_cnt + 1'b1 : '0;
      if (state == LOAD) begin
        cmp.cmp_timeout <= window_cfg;
        expect_s        <= expect_ge;
      end
      if (grading) meas_pass <= pass_now;
      // A grade landing with alarm_clr wins: flags set and the count takes its graded value
      fail_cnt <= grading ? fail_nxt : (alarm_clr ? '0 : fail_cnt);
      alarm    <= (grading && fail_thresh != '0 && fail_nxt >= fail_thresh) || (alarm && !alarm_clr);
      wdog_err <= wdog_hit || (wdog_err && !alarm_clr);
    end
  end
endmodule

// File: tb/tb_freq_monitor_ctrl.sv
// tb_freq_monitor_ctrl: directed stimulus with a queue scoreboard checked on every meas_valid
module tb_freq_monitor_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic expect_ge = 1'b0, alarm_clr = 1'b0;
  logic [31:0] window_cfg = '0;
  logic [15:0] gap_cfg = '0;
  logic [3:0]  fail_thresh = '0;
  logic [39:0] wdog_cfg = '0;
  logic busy, meas_valid, meas_pass, alarm, wdog_err;
  logic [3:0] fail_cnt;
  int tests = 0, fails = 0, lat = 5;
  logic gv = 1'b0;
  logic [5:0] exp_q[$];
  freq_monitor_ctrl_if cmp_if();
  freq_monitor_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .continuous(continuous),
    .expect_ge(expect_ge), .window_cfg(window_cfg), .gap_cfg(gap_cfg), .fail_thresh(fail_thresh),
    .wdog_cfg(wdog_cfg), .alarm_clr(alarm_clr), .cmp(cmp_if), .busy(busy), .meas_valid(meas_valid),
    .meas_pass(meas_pass), .fail_cnt(fail_cnt), .alarm(alarm), .wdog_err(wdog_err)
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  // Comparator stand-in: raises done lat cycles into an enable, drops it once enable falls
  initial begin
    int cyc;
    cyc = 0;
    cmp_if.cmp_done = 1'b0;
    cmp_if.cmp_ge = 1'b0;
    forever begin
      @(negedge clk);
      if (cmp_if.cmp_enable !== 1'b1) begin
        cmp_if.cmp_done = 1'b0;
        cyc = 0;
      end else if (cyc >= lat) begin
        cmp_if.cmp_done = 1'b1;
        cmp_if.cmp_ge = gv;
      end else cyc++;
    end
  end
  initial forever begin
    @(negedge clk);
    if (meas_valid === 1'b1) begin
      logic [5:0] e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_meas_valid: got 1 expected 0");
      end else begin
        e = exp_q.pop_front();
        check("meas_pass", meas_pass, e[5]);
        check("fail_cnt", fail_cnt, e[4:1]);
        check("alarm", alarm, e[0]);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end
  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start;
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask
  task automatic pulse_stop;
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask
  task automatic pulse_clr;
    alarm_clr = 1'b1; @(negedge clk); alarm_clr = 1'b0;
  endtask
  task automatic wait_valid(int budget);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (meas_valid !== 1'b1 && t < budget);
    check("meas_valid_seen", meas_valid, 1);
  endtask
  task automatic wait_idle(int budget);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < budget) begin @(negedge clk); t++; end
    check("busy_drop", busy, 0);
    check("enable_idle", cmp_if.cmp_enable, 0);
  endtask
  task automatic low_run(string name, int expv);
    int n;
    n = 0;
    while (cmp_if.cmp_enable !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    check(name, n, expv);
  endtask
  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_enable"}, cmp_if.cmp_enable, 0);
    check({tag, "_timeout"}, cmp_if.cmp_timeout, 0);
    check({tag, "_valid"}, meas_valid, 0);
    check({tag, "_pass"}, meas_pass, 0);
    check({tag, "_fail_cnt"}, fail_cnt, 0);
    check({tag, "_alarm"}, alarm, 0);
    check({tag, "_wdog_err"}, wdog_err, 0);
  endtask
  initial begin
    int n;
    cycles(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    cycles(1);
    // single shot pass, with window_cfg changed mid-run
    expect_ge = 1'b1; window_cfg = 32'h1234_5678; fail_thresh = 4'd3; gap_cfg = 16'd10;
    lat = 50; gv = 1'b1;
    exp_q.push_back({1'b1, 4'd0, 1'b0});
    pulse_start;
    check("load_enable", cmp_if.cmp_enable, 0);
    check("load_busy", busy, 1);
    cycles(1);
    check("latency_enable", cmp_if.cmp_enable, 1);
    check("cmp_timeout", cmp_if.cmp_timeout, 32'h1234_5678);
    window_cfg = 32'h0000_dead;
    wait_valid(200);
    wait_idle(20);
    check("timeout_held", cmp_if.cmp_timeout, 32'h1234_5678);
    // continuous failures reaching threshold 3
    continuous = 1'b1; lat = 5; gv = 1'b0;
    exp_q.push_back({1'b0, 4'd1, 1'b0});
    exp_q.push_back({1'b0, 4'd2, 1'b0});
    exp_q.push_back({1'b0, 4'd3, 1'b1});
    pulse_start;
    wait_valid(100);
    low_run("gap10_low_cycles", 14);
    wait_valid(100);
    wait_valid(100);
    pulse_stop;
    wait_idle(20);
    check("alarm_held", alarm, 1);
    // clear, then alarm_clr colliding with an alarm-setting grade
    pulse_clr;
    check("clr_alarm", alarm, 0);
    check("clr_fail_cnt", fail_cnt, 0);
    continuous = 1'b0; fail_thresh = 4'd1;
    exp_q.push_back({1'b0, 4'd1, 1'b1});
    alarm_clr = 1'b1;
    pulse_start;
    wait_valid(100);
    alarm_clr = 1'b0;
    cycles(1);
    check("alarm_after_collision", alarm, 1);
    wait_idle(20);
    // fail, fail, pass
    pulse_clr;
    fail_thresh = 4'd3; continuous = 1'b1; gap_cfg = 16'd3;
    exp_q.push_back({1'b0, 4'd1, 1'b0});
    exp_q.push_back({1'b0, 4'd2, 1'b0});
    exp_q.push_back({1'b1, 4'd0, 1'b0});
    pulse_start;
    wait_valid(100);
    low_run("gap3_low_cycles", 7);
    wait_valid(100);
    gv = 1'b1;
    wait_valid(100);
    pulse_stop;
    wait_idle(20);
    check("alarm_stays_low", alarm, 0);
    // saturation with alarm disabled and zero gap
    fail_thresh = 4'd0; gap_cfg = 16'd0; gv = 1'b0; lat = 2;
    for (int i = 1; i <= 17; i++) exp_q.push_back({1'b0, (i > 15) ? 4'd15 : 4'(i), 1'b0});
    pulse_start;
    wait_valid(100);
    low_run("gap0_low_cycles", 4);
    for (int i = 2; i <= 17; i++) wait_valid(100);
    pulse_stop;
    wait_idle(20);
    check("sat_no_alarm", alarm, 0);
    // watchdog with a comparator that never answers
    pulse_clr;
    continuous = 1'b0; wdog_cfg = 40'd100; lat = 1_000_000;
    pulse_start;
    cycles(1);
    n = 0;
    while (cmp_if.cmp_enable === 1'b1 && n < 300) begin n++; @(negedge clk); end
    check("wdog_enable_cycles", n, 101);
    check("wdog_err_set", wdog_err, 1);
    wait_idle(20);
    check("wdog_err_held", wdog_err, 1);
    // stop during MEASURE in continuous mode
    wdog_cfg = '0; continuous = 1'b1; lat = 30; gv = 1'b0; fail_thresh = 4'd1;
    exp_q.push_back({1'b0, 4'd1, 1'b1});
    pulse_start;
    cycles(11);
    check("mid_measure_enable", cmp_if.cmp_enable, 1);
    pulse_stop;
    wait_valid(100);
    wait_idle(20);
    n = 0;
    repeat (60) begin @(negedge clk); if (cmp_if.cmp_enable === 1'b1) n++; end
    check("no_restart", n, 0);
    // reset mid-MEASURE clears everything including sticky flags
    continuous = 1'b0; lat = 1_000_000;
    pulse_start;
    cycles(5);
    check("pre_reset_enable", cmp_if.cmp_enable, 1);
    check("pre_reset_wdog_err", wdog_err, 1);
    reset_n = 1'b0;
    cycles(1);
    check_all_zero("midrun_reset");
    reset_n = 1'b1;
    cycles(3);
    check("post_reset_idle", busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
